// File: rtl/deser_8bit.sv
`default_nettype none
// ============================================================================
// Module   : deser_8bit
// Purpose  : LSB-first serial-to-8-bit deserializer with sync-word alignment
//            and a keep-alive timeout.
// Revision : 1.0
// ============================================================================
module deser_8bit #(
  parameter logic [7:0] SYNC_WORD    = 8'hBC,
  parameter int         SYNC_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ser_in,
  input  logic       ser_valid,
  input  logic       resync,
  output logic [7:0] data_8b_out,
  output logic       data_en,
  output logic       locked,
  output logic       sync_seen,
  output logic       lock_lost
);

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [7:0] TIMEOUT   = 8'(SYNC_TIMEOUT);

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic [7:0] sr;
  logic [2:0] bit_cnt;
  logic [7:0] word_cnt;

  logic [7:0] nxt_word;
  logic       is_sync;
  logic       under_limit;
  logic       sync_nxt;
  logic       de_nxt;
  logic       ll_nxt;

  assign nxt_word    = {ser_in, sr[7:1]};
  assign is_sync     = (nxt_word == SYNC_WORD);
  assign under_limit = (word_cnt < TIMEOUT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; resync outranks any bit arriving in the same cycle
  always_comb begin
    state_nxt = state;
    if (resync) begin
      state_nxt = ST_HUNT;
    end else if (ser_valid) begin
      case (state)
        ST_HUNT: begin
          if (is_sync) state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          if (bit_cnt == 3'd7 && !is_sync && !under_limit) state_nxt = ST_HUNT;
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  // Output decode: pulse values to be registered at this edge
  always_comb begin
    sync_nxt = 1'b0;
    de_nxt   = 1'b0;
    ll_nxt   = 1'b0;
    if (!resync && ser_valid) begin
      if (state == ST_HUNT) begin
        sync_nxt = is_sync;
      end else if (bit_cnt == 3'd7) begin
        if (is_sync)          sync_nxt = 1'b1;
        else if (under_limit) de_nxt   = 1'b1;
        else                  ll_nxt   = 1'b1;
      end
    end
  end

  // Shift register, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr          <= 8'h00;
      bit_cnt     <= 3'd0;
      word_cnt    <= 8'd0;
      data_8b_out <= 8'h00;
      data_en     <= 1'b0;
      sync_seen   <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      data_en   <= de_nxt;
      sync_seen <= sync_nxt;
      lock_lost <= ll_nxt;
      if (resync) begin
        sr       <= 8'h00;
        bit_cnt  <= 3'd0;
        word_cnt <= 8'd0;
      end else if (ser_valid) begin
        sr <= nxt_word;
        if (state == ST_HUNT) begin
          bit_cnt  <= 3'd0;
          word_cnt <= 8'd0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (is_sync || !under_limit) word_cnt <= 8'd0;
            else                         word_cnt <= word_cnt + 8'd1;
          end
        end
        if (de_nxt) data_8b_out <= nxt_word;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_deser_8bit.sv
`default_nettype none
// ============================================================================
// Module   : tb_deser_8bit
// Purpose  : Directed, table-driven self-checking bench for deser_8bit.
// Revision : 1.0
// ============================================================================
module tb_deser_8bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ser_in;
  logic       ser_valid;
  logic       resync;
  logic [7:0] data_8b_out;
  logic       data_en;
  logic       locked;
  logic       sync_seen;
  logic       lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int de_cnt, ss_cnt, ll_cnt;

  typedef struct {
    logic       resync_first;
    logic [7:0] value;
    int         gap;
    int         exp_de;
    int         exp_ss;
    int         exp_ll;
    logic [7:0] exp_data;
    logic       exp_locked;
  } vec_t;

  vec_t tbl[14];

  always #5 clk = ~clk;

  deser_8bit #(
    .SYNC_WORD   (8'hBC),
    .SYNC_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .resync     (resync),
    .data_8b_out(data_8b_out),
    .data_en    (data_en),
    .locked     (locked),
    .sync_seen  (sync_seen),
    .lock_lost  (lock_lost)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
    de_cnt += int'(data_en);
    ss_cnt += int'(sync_seen);
    ll_cnt += int'(lock_lost);
  endtask

  task automatic clear_counts();
    de_cnt = 0;
    ss_cnt = 0;
    ll_cnt = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      @(negedge clk);
      ser_valid = 1'b0;
      ser_in    = ~b;
      sample();
    end
    @(negedge clk);
    ser_in    = b;
    ser_valid = 1'b1;
    sample();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    clear_counts();
    for (int i = 0; i < 8; i++) send_bit(b[i], gap);
  endtask

  initial begin
    logic [7:0] bc;
    bc = 8'hBC;

    tbl[0]  = '{1'b0, 8'hBC, 0, 0, 1, 0, 8'h00, 1'b1};
    tbl[1]  = '{1'b0, 8'hA5, 0, 1, 0, 0, 8'hA5, 1'b1};
    tbl[2]  = '{1'b0, 8'hBC, 0, 0, 1, 0, 8'hA5, 1'b1};
    tbl[3]  = '{1'b0, 8'h11, 0, 1, 0, 0, 8'h11, 1'b1};
    tbl[4]  = '{1'b0, 8'hBC, 0, 0, 1, 0, 8'h11, 1'b1};
    tbl[5]  = '{1'b0, 8'h22, 0, 1, 0, 0, 8'h22, 1'b1};
    tbl[6]  = '{1'b0, 8'hBC, 0, 0, 1, 0, 8'h22, 1'b1};
    tbl[7]  = '{1'b0, 8'h01, 0, 1, 0, 0, 8'h01, 1'b1};
    tbl[8]  = '{1'b0, 8'h02, 0, 1, 0, 0, 8'h02, 1'b1};
    tbl[9]  = '{1'b0, 8'h03, 0, 1, 0, 0, 8'h03, 1'b1};
    tbl[10] = '{1'b0, 8'h04, 0, 1, 0, 0, 8'h04, 1'b1};
    tbl[11] = '{1'b0, 8'h05, 0, 0, 0, 1, 8'h04, 1'b0};
    tbl[12] = '{1'b1, 8'hBC, 0, 0, 1, 0, 8'h04, 1'b1};
    tbl[13] = '{1'b0, 8'h3C, 3, 1, 0, 0, 8'h3C, 1'b1};

    // Reset held with toggling inputs
    rst_n     = 1'b0;
    ser_in    = 1'b0;
    ser_valid = 1'b0;
    resync    = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ser_in    = 1'($urandom_range(0, 1));
      ser_valid = 1'($urandom_range(0, 1));
      resync    = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    check("rst_data", data_8b_out, 8'h00);
    check("rst_data_en", data_en, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_seen", sync_seen, 0);
    check("rst_lock_lost", lock_lost, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    ser_valid = 1'b0;
    resync    = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_locked", locked, 0);

    // Word-level vector table
    for (int v = 0; v < 14; v++) begin
      if (tbl[v].resync_first) begin
        @(negedge clk);
        resync    = 1'b1;
        ser_valid = 1'b0;
        @(posedge clk);
        #1;
        resync = 1'b0;
      end
      send_byte(tbl[v].value, tbl[v].gap);
      check($sformatf("v%0d_data_en_count", v), de_cnt, tbl[v].exp_de);
      check($sformatf("v%0d_sync_seen_count", v), ss_cnt, tbl[v].exp_ss);
      check($sformatf("v%0d_lock_lost_count", v), ll_cnt, tbl[v].exp_ll);
      check($sformatf("v%0d_data", v), data_8b_out, tbl[v].exp_data);
      check($sformatf("v%0d_locked", v), locked, tbl[v].exp_locked);
    end

    // resync mid-word while locked, bit valid on the same cycle
    clear_counts();
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    @(negedge clk);
    resync    = 1'b1;
    ser_valid = 1'b1;
    ser_in    = 1'b1;
    sample();
    resync    = 1'b0;
    check("resync_locked", locked, 0);
    check("resync_no_strobe", de_cnt, 0);
    check("resync_no_sync", ss_cnt, 0);
    check("resync_no_lost", ll_cnt, 0);
    check("resync_data_hold", data_8b_out, 8'h3C);

    // Async reset pulse in the middle of a hunt
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    ser_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", data_8b_out, 8'h00);
    check("async_rst_locked", locked, 0);
    #1;
    rst_n = 1'b1;

    // Re-lock requires the complete sync pattern
    clear_counts();
    for (int i = 0; i < 7; i++) send_bit(bc[i], 0);
    check("partial_sync_locked", locked, 0);
    check("partial_sync_seen", ss_cnt, 0);
    send_bit(bc[7], 0);
    check("relock_locked", locked, 1);
    check("relock_sync_seen", ss_cnt, 1);
    check("relock_no_strobe", de_cnt, 0);
    @(negedge clk);
    ser_valid = 1'b0;
    @(posedge clk);
    #1;
    check("sync_pulse_one_cycle", sync_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
